tsmp_cmd_parser: RTL

//  Sits directly downstream of the TSMP packet filter. Consumes its 9-bit framed byte stream
//  (bit 8 marks first and last byte of a packet) and decodes TSMP read/write/config frames.

---
 rtl/tsmp_cmd_parser.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/tsmp_cmd_parser.sv
// TSMP command parser: decodes framed read/write/config requests from the packet filter
// into single commands on a valid/ready port, counting malformed and busy-dropped frames.
module tsmp_cmd_parser #(
  parameter int          DATA_WIDTH = 9,
  parameter logic [15:0] ETHERTYPE  = 16'hFF01,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] iv_data,
  input  logic                  i_data_wr,
  output logic                  o_cmd_valid,
  input  logic                  i_cmd_ready,
  output logic [1:0]            ov_cmd_type,
  output logic [31:0]           ov_cmd_addr,
  output logic [31:0]           ov_cmd_wdata,
  output logic [47:0]           ov_cmd_smac,
  output logic [CNT_WIDTH-1:0]  ov_err_cnt,
  output logic [CNT_WIDTH-1:0]  ov_drop_cnt
);

  typedef enum logic {IDLE, RECV} state_e;

  state_e                state_q, state_d;
  logic [5:0]            idx_q, idx_d;
  logic [47:0]           smac_q, smac_d;
  logic [15:0]           etype_q, etype_d;
  logic [7:0]            type_q, type_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic                  cmd_valid_q, cmd_valid_d;
  logic [1:0]            cmd_type_q, cmd_type_d;
  logic [31:0]           cmd_addr_q, cmd_addr_d;
  logic [31:0]           cmd_wdata_q, cmd_wdata_d;
  logic [47:0]           cmd_smac_q, cmd_smac_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

  logic                  delim;
  logic [7:0]            byte_v;
  logic                  store;
  logic                  tail;
  logic [5:0]            pos;
  logic                  type_ok;
  logic                  len_ok;
  logic                  good;
  logic                  slot_free;

  assign delim  = iv_data[DATA_WIDTH-1];
  assign byte_v = iv_data[7:0];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    smac_d      = smac_q;
    etype_d     = etype_q;
    type_d      = type_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cmd_valid_d = cmd_valid_q && !i_cmd_ready;
    cmd_type_d  = cmd_type_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_smac_d  = cmd_smac_q;
    err_cnt_d   = err_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    store       = 1'b0;
    tail        = 1'b0;
    pos         = 6'd0;

    case (state_q)
      IDLE: begin
        if (i_data_wr && delim) begin
          store   = 1'b1;
          idx_d   = 6'd1;
          state_d = RECV;
        end
      end
      RECV: begin
        if (i_data_wr) begin
          store = 1'b1;
          pos   = idx_q;
          idx_d = (idx_q == 6'd63) ? 6'd63 : idx_q + 6'd1;
          if (delim) begin
            tail    = 1'b1;
            idx_d   = 6'd0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Field registers are not cleared per frame: any frame short enough to leave
    // stale bytes in them fails the length check anyway.
    if (store) begin
      case (pos)
        6'd6:  smac_d[47:40]  = byte_v;
        6'd7:  smac_d[39:32]  = byte_v;
        6'd8:  smac_d[31:24]  = byte_v;
        6'd9:  smac_d[23:16]  = byte_v;
        6'd10: smac_d[15:8]   = byte_v;
        6'd11: smac_d[7:0]    = byte_v;
        6'd12: etype_d[15:8]  = byte_v;
        6'd13: etype_d[7:0]   = byte_v;
        6'd14: type_d         = byte_v;
        6'd15: addr_d[31:24]  = byte_v;
        6'd16: addr_d[23:16]  = byte_v;
        6'd17: addr_d[15:8]   = byte_v;
        6'd18: addr_d[7:0]    = byte_v;
        6'd19: wdata_d[31:24] = byte_v;
        6'd20: wdata_d[23:16] = byte_v;
        6'd21: wdata_d[15:8]  = byte_v;
        6'd22: wdata_d[7:0]   = byte_v;
        default: ;
      endcase
    end

    // Evaluation sees the tail byte already merged; frame length is idx_q + 1.
    type_ok   = (type_d == 8'd1) || (type_d == 8'd2) || (type_d == 8'd3);
    len_ok    = (type_d == 8'd1) ? (idx_q >= 6'd18) : (idx_q >= 6'd22);
    good      = tail && (etype_d == ETHERTYPE) && type_ok && len_ok;
    slot_free = !cmd_valid_q || i_cmd_ready;

    if (tail && !good) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end else if (good && slot_free) begin
      cmd_valid_d = 1'b1;
      cmd_type_d  = type_d[1:0];
      cmd_addr_d  = addr_d;
      cmd_wdata_d = (type_d == 8'd1) ? 32'd0 : wdata_d;
      cmd_smac_d  = smac_d;
    end else if (good) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      idx_q       <= 6'd0;
      smac_q      <= '0;
      etype_q     <= '0;
      type_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_smac_q  <= '0;
      err_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      smac_q      <= smac_d;
      etype_q     <= etype_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_smac_q  <= cmd_smac_d;
      err_cnt_q   <= err_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign o_cmd_valid  = cmd_valid_q;
  assign ov_cmd_type  = cmd_type_q;
  assign ov_cmd_addr  = cmd_addr_q;
  assign ov_cmd_wdata = cmd_wdata_q;
  assign ov_cmd_smac  = cmd_smac_q;
  assign ov_err_cnt   = err_cnt_q;
  assign ov_drop_cnt  = drop_cnt_q;

endmodule
